id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports id_read_data1, id_read_data2, id_sign_ext_imm  input  DATA_W each  ID-stage operands.
REQ-006 SHALL have ports id_rs, id_rt, id_rd  input  RA_W each  ID-stage register addresses.
REQ-007 SHALL have port id_func  input  6  instruction function field.
REQ-008 SHALL have port id_aluop  input  2  ALU op class for the ALU controller.
REQ-009 SHALL have ports id_regdst, id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite  input  1 each  ID-stage control.
REQ-010 SHALL have port id_valid  input  1  ID holds a real instruction.
REQ-011 SHALL have ports flush  input  1 (squash ID/EX contents) and hold  input  1 (downstream freeze).
REQ-012 SHALL have outputs ex_* mirroring every id_* input in REQ-005..REQ-010, same widths, registered.
REQ-013 SHALL have port load_use_stall  output  1  combinational request to freeze PC and IF/ID.

Function
REQ-014 SHALL be a single register stage: in a load cycle, every ex_* output equals the corresponding id_* value from the previous rising edge (latency 1).
REQ-015 SHALL define a bubble as: all ex_ control bits 0, ex_aluop 2'b00, ex_func 0, all ex_ data/address fields 0, ex_valid 0.
REQ-016 SHALL drive load_use_stall = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)), purely combinational from current outputs and inputs.
REQ-017 SHALL resolve each edge in fixed priority: rst > flush > hold > load_use_stall > load.
REQ-018 SHALL load a bubble on an edge where flush=1 (rst=0), regardless of hold and load_use_stall.
REQ-019 SHALL retain all ex_* values unchanged on an edge where hold=1 and rst=flush=0.
REQ-020 SHALL load a bubble on an edge where load_use_stall=1 and rst=flush=hold=0; the ID instruction stays in ID because upstream is frozen.
REQ-021 SHALL load id_* values on an edge where rst=flush=hold=load_use_stall=0.
REQ-022 SHALL insert exactly one bubble per load-use hazard: after the bubble, ex_valid=0 deasserts load_use_stall and the held ID instruction loads on the next edge.
REQ-023 SHALL never assert load_use_stall for ex_rt = 0 or while ex_valid=0.
REQ-024 SHALL pass id_aluop and id_func unmodified; the stage does not decode them.

Reset
REQ-025 SHALL, on an edge with rst=1, load the bubble of REQ-015 into all ex_* outputs, overriding flush and hold.
REQ-026 SHALL hold load_use_stall at 0 from the first edge after rst until a valid load enters the stage.
REQ-027 SHALL make rst mid-hold or mid-hazard discard the held or stalled contents with no residual state.

Verification
REQ-028 Load pass-through: id_aluop=2'b10, id_func=6'b100010, id_regwrite=1, id_valid=1, no hazard -> next edge ex_aluop=2'b10, ex_func=6'b100010, ex_regwrite=1, ex_valid=1.
REQ-029 Load-use: ex = lw with ex_memread=1, ex_rt=5, ex_valid=1; id_rs=5, id_valid=1 -> load_use_stall=1 same cycle; next edge bubble (ex_valid=0, ex_regwrite=0); following edge ID instruction loaded.
REQ-030 No false stall: ex_memread=1, ex_rt=0, id_rs=0 -> load_use_stall=0, normal load.
REQ-031 Hold: hold=1 for 3 edges with changing id_* -> ex_* constant; hold=0 -> next edge loads current id_*.
REQ-032 Flush vs hold: flush=1 and hold=1 same edge -> bubble loaded (ex_valid=0, ex_memwrite=0).
REQ-033 Reset mid-stall: load_use_stall=1 and rst=1 same edge -> all ex_* 0, load_use_stall=0 next cycle.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Each edge resolves rst > flush > hold > load-use bubble > load.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [DATA_W-1:0] id_sign_ext_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [5:0]        id_func,
  input  logic [1:0]        id_aluop,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              hold,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_sign_ext_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [5:0]        ex_func,
  output logic [1:0]        ex_aluop,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_valid,
  output logic              load_use_stall
);

  typedef struct packed {
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] sign_ext_imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [5:0]        func;
    logic [1:0]        aluop;
    logic              regdst;
    logic              alusrc;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
    logic              valid;
  } stage_t;

  // An all-zero stage is the bubble: no control, no data, not valid.
  stage_t id_stage;
  stage_t stage_d;
  stage_t stage_q;

  assign id_stage = {id_read_data1, id_read_data2, id_sign_ext_imm,
                     id_rs, id_rt, id_rd, id_func, id_aluop,
                     id_regdst, id_alusrc, id_memread, id_memwrite,
                     id_memtoreg, id_regwrite, id_valid};

  assign load_use_stall = stage_q.valid & stage_q.memread &
                          (stage_q.rt != '0) & id_valid &
                          ((stage_q.rt == id_rs) | (stage_q.rt == id_rt));

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (load_use_stall) begin
      stage_d = '0;
    end else begin
      stage_d = id_stage;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign {ex_read_data1, ex_read_data2, ex_sign_ext_imm,
          ex_rs, ex_rt, ex_rd, ex_func, ex_aluop,
          ex_regdst, ex_alusrc, ex_memread, ex_memwrite,
          ex_memtoreg, ex_regwrite, ex_valid} = stage_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed vector bench for id_ex_reg: pass-through, load-use bubble,
// hold, flush/hold priority and reset mid-hazard.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [1:0]  aluop;
    logic [5:0]  ctl;   // regdst, alusrc, memread, memwrite, memtoreg, regwrite
    logic        valid;
  } stg_t;

  typedef struct {
    logic rst;
    logic flush;
    logic hold;
    stg_t id;
    logic exp_stall;
    stg_t exp_ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic hold = 1'b0;
  stg_t id_in = '0;
  stg_t ex_out;

  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_func;
  logic [1:0]  ex_aluop;
  logic ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_valid;
  logic stall;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_read_data1(id_in.rd1), .id_read_data2(id_in.rd2), .id_sign_ext_imm(id_in.imm),
    .id_rs(id_in.rs), .id_rt(id_in.rt), .id_rd(id_in.rd),
    .id_func(id_in.func), .id_aluop(id_in.aluop),
    .id_regdst(id_in.ctl[5]), .id_alusrc(id_in.ctl[4]), .id_memread(id_in.ctl[3]),
    .id_memwrite(id_in.ctl[2]), .id_memtoreg(id_in.ctl[1]), .id_regwrite(id_in.ctl[0]),
    .id_valid(id_in.valid), .flush(flush), .hold(hold),
    .ex_read_data1(ex_rd1), .ex_read_data2(ex_rd2), .ex_sign_ext_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_func(ex_func), .ex_aluop(ex_aluop),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_valid(ex_valid), .load_use_stall(stall)
  );

  assign ex_out = {ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_func, ex_aluop,
                   ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg,
                   ex_regwrite, ex_valid};

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  function automatic stg_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [5:0] fn, input logic [1:0] op,
                              input logic [5:0] ctl, input logic v);
    return {a, b, c, rs, rt, rd, fn, op, ctl, v};
  endfunction

  task automatic add(input logic r, input logic f, input logic h, input stg_t id,
                     input logic st, input stg_t ex);
    vec_t v;
    v.rst = r; v.flush = f; v.hold = h; v.id = id; v.exp_stall = st; v.exp_ex = ex;
    vecs.push_back(v);
  endtask

  task automatic chk_stall(input string nm, input logic exp);
    n_cmp++;
    if (stall !== exp) begin
      n_bad++;
      $display("FAIL %s: load_use_stall got %b want %b", nm, stall, exp);
    end
  endtask

  task automatic chk_ex(input string nm, input stg_t exp);
    n_cmp++;
    if (ex_out !== exp) begin
      n_bad++;
      $display("FAIL %s: ex_* got %h want %h", nm, ex_out, exp);
    end
  endtask

  initial begin
    stg_t A, LW, B, LW0, C0, D, LWI, BI, Z;
    Z   = '0;
    A   = mk(32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 6'b100010, 2'b10, 6'b100001, 1'b1);
    LW  = mk(32'h100, 32'h0, 32'h4, 5'd1, 5'd5, 5'd0, 6'b000000, 2'b00, 6'b011011, 1'b1);
    B   = mk(32'h55, 32'h66, 32'h0, 5'd5, 5'd6, 5'd7, 6'b100000, 2'b10, 6'b100001, 1'b1);
    LW0 = mk(32'h200, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0, 6'b000000, 2'b00, 6'b011011, 1'b1);
    C0  = mk(32'h77, 32'h88, 32'h99, 5'd0, 5'd9, 5'd10, 6'b100100, 2'b10, 6'b100001, 1'b1);
    D   = mk(32'hAA, 32'hBB, 32'hCC, 5'd2, 5'd5, 5'd8, 6'b100101, 2'b10, 6'b100001, 1'b1);
    LWI = LW; LWI.valid = 1'b0;
    BI  = B;  BI.valid  = 1'b0;

    //   rst flush hold id   stall ex-after-edge
    add(0, 0, 0, A,   0, A);    // plain pass-through of aluop/func/regwrite
    add(0, 0, 0, LW,  0, LW);
    add(0, 0, 0, B,   1, Z);    // load-use on rs -> bubble
    add(0, 0, 0, B,   0, B);    // held instruction loads after one bubble
    add(0, 0, 0, LW0, 0, LW0);
    add(0, 0, 0, C0,  0, C0);   // ex_rt = 0 never stalls
    add(0, 0, 1, A,   0, C0);   // hold x3 with changing inputs
    add(0, 0, 1, LW,  0, C0);
    add(0, 0, 1, B,   0, C0);
    add(0, 0, 0, A,   0, A);
    add(0, 0, 0, LW,  0, LW);
    add(0, 1, 1, B,   1, Z);    // flush beats hold and stall
    add(0, 0, 0, LW,  0, LW);
    add(0, 0, 1, B,   1, LW);   // hold beats stall
    add(1, 0, 0, B,   1, Z);    // reset mid-hazard
    add(0, 0, 0, B,   0, B);
    add(0, 0, 0, LWI, 0, LWI);
    add(0, 0, 0, B,   0, B);    // invalid load in EX never stalls
    add(0, 0, 0, LW,  0, LW);
    add(0, 0, 0, D,   1, Z);    // load-use on rt
    add(0, 0, 0, D,   0, D);
    add(0, 0, 0, LW,  0, LW);
    add(0, 0, 0, BI,  0, BI);   // invalid ID instruction never stalls

    // Reset from unknown state
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; hold = 1'b1; id_in = A;
    @(posedge clk); #1;
    n_vec++;
    chk_ex("reset_state", Z);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; hold = 1'b0; id_in = B;
    #1 chk_stall("reset_stall", 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; hold = vecs[i].hold; id_in = vecs[i].id;
      #1 chk_stall($sformatf("v%0d_stall", i), vecs[i].exp_stall);
      @(posedge clk); #1;
      n_vec++;
      chk_ex($sformatf("v%0d_ex", i), vecs[i].exp_ex);
    end

    // Hand sequence: hazard stays stalled while held, one bubble once hold drops
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; hold = 1'b0; id_in = LW;
    @(posedge clk); #1;
    n_vec++;
    chk_ex("seq_lw", LW);
    @(negedge clk);
    id_in = B; hold = 1'b1;
    #1 chk_stall("seq_hold_stall", 1'b1);
    @(posedge clk); #1;
    n_vec++;
    chk_ex("seq_hold_keep", LW);
    @(negedge clk);
    hold = 1'b0;
    #1 chk_stall("seq_stall_again", 1'b1);
    @(posedge clk); #1;
    n_vec++;
    chk_ex("seq_bubble", Z);
    @(negedge clk);
    #1 chk_stall("seq_released", 1'b0);
    @(posedge clk); #1;
    n_vec++;
    chk_ex("seq_load_b", B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
